psum_accumulator: RTL

- Downstream stage of the conv processing element; consumes its registered 19-bit partial sums.
- Accumulates K consecutive psums (one output pixel = K taps) into a wide accumulator.
- Rescales the sum by an arithmetic right shift and saturates it to an O_Y-bit signed activation.
- Presents the activation on a valid/ready output and back-pressures the upstream when the output is not taken.

---
 rtl/psum_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//   Accumulates K consecutive signed partial sums from the conv PE into one
//   output pixel, rescales by an arithmetic right shift (floor), saturates to
//   an O_Y-bit signed activation and presents it on a valid/ready interface.
//   While a finished activation is not taken, the upstream is back-pressured.
//
//   Optional build macro: PSUM_ACCUMULATOR_RELU_EN
//     defined   -> negative shifted sums clamp to 0 before saturation
//     undefined -> plain signed saturation
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_clear  synchronous clear, drops the partial pixel and the held result
//   i_valid  upstream psum valid
//   o_ready  upstream may transfer (combinational)
//   i_psum   signed partial sum [I_PSUM-1:0]
//   o_valid  activation valid (registered)
//   i_ready  downstream accepts activation
//   o_y      signed activation [O_Y-1:0] (registered)
// -----------------------------------------------------------------------------
module psum_accumulator #(
    parameter int I_PSUM = 19,
    parameter int O_ACC  = 23,
    parameter int O_Y    = 8,
    parameter int K      = 9,
    parameter int CNT_W  = 4,
    parameter int SHIFT  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [I_PSUM-1:0] i_psum,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [O_Y-1:0]    o_y
);

    typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

    localparam int                      Y_MAX_I = (1 << (O_Y - 1)) - 1;
    localparam logic signed [O_ACC-1:0] Y_MAX   = O_ACC'(Y_MAX_I);
    localparam logic signed [O_ACC-1:0] Y_MIN   = O_ACC'(-Y_MAX_I - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(K - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [O_ACC-1:0]   r_acc;
    logic [O_Y-1:0]            r_y;

    logic                      w_accept;
    logic                      w_last;
    logic signed [O_ACC-1:0]   w_psum_ext;
    logic signed [O_ACC-1:0]   w_sum;
    logic signed [O_ACC-1:0]   w_shift;
    logic signed [O_ACC-1:0]   w_clamp;

    // In S_HOLD the ready passes through from downstream so a new psum can be
    // accepted in the same cycle the held activation leaves (no bubble).
    // A clear cycle always reports ready; its input is discarded anyway.
    assign o_ready  = i_clear | (r_state == S_ACC) | i_ready;
    assign w_accept = i_valid & o_ready & ~i_clear;
    assign w_last   = (r_cnt == CNT_LAST);

    // A new pixel starts from zero rather than from the stale accumulator,
    // so acc never needs an explicit reset at pixel completion.
    assign w_psum_ext = {{(O_ACC - I_PSUM){i_psum[I_PSUM-1]}}, i_psum};
    assign w_sum      = ((r_cnt == '0) ? '0 : r_acc) + w_psum_ext;
    assign w_shift    = w_sum >>> SHIFT;

    always_comb begin
        w_clamp = w_shift;
`ifdef PSUM_ACCUMULATOR_RELU_EN
        if (w_shift < 0)
            w_clamp = '0;
        else if (w_shift > Y_MAX)
            w_clamp = Y_MAX;
`else
        if (w_shift > Y_MAX)
            w_clamp = Y_MAX;
        else if (w_shift < Y_MIN)
            w_clamp = Y_MIN;
`endif
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = S_ACC;
        end else if (w_accept && w_last) begin
            w_state_next = S_HOLD;
        end else if (r_state == S_HOLD && i_ready) begin
            w_state_next = S_ACC;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_ACC;
        else
            r_state <= w_state_next;
    end

    // Datapath. In S_HOLD with i_ready low, o_ready is low so w_accept is 0
    // and everything below holds by default.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_y   <= w_clamp[O_Y-1:0];
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // o_valid is exactly the registered S_HOLD state.
    assign o_valid = (r_state == S_HOLD);
    assign o_y     = r_y;

endmodule
